// File: rtl/warp_scheduler.sv
// -----------------------------------------------------------------------------
// warp_scheduler
//
// Sequences the per-warp pipeline phases of a compute core. It time-multiplexes
// the shared fetch/decode/ALU/LSU datapath between NUM_WARPS warps. After every
// retired instruction it hands the datapath to the next eligible warp in
// round-robin order. When every participating warp has executed a return, it
// reports kernel completion.
//
// Optional feature macro: WARP_SCHED_PERF_EN
//   When defined, the block gains two saturating 32-bit counters:
//   - perf_cycles:  cycles spent busy
//   - perf_retired: UPDATE cycles
//   When undefined, the counters and their ports do not exist.
//
// Ports
//   clk                   in   core clock
//   reset                 in   asynchronous, active-low reset
//   start                 in   single-cycle kernel launch pulse (ignored while busy)
//   warp_participate_mask in   warps taking part in the kernel, sampled on start
//   fetch_valid           in   fetcher holds an instruction for the current warp
//   decoded_mem_access    in   decoded instruction uses the LSU
//   lsu_done              in   LSU finished the current warp's access (pulse)
//   decoded_ret           in   decoded instruction is a return
//   warp_enable           out  one-hot register-file enable of the current warp
//   warp_state            out  phase broadcast to all register files (FSM state)
//   current_warp          out  index of the warp being served
//   busy                  out  kernel running (FETCH through DONE inclusive)
//   done                  out  one-cycle pulse once all participating warps returned
//   perf_cycles           out  (WARP_SCHED_PERF_EN only) busy cycle counter
//   perf_retired          out  (WARP_SCHED_PERF_EN only) UPDATE cycle counter
// -----------------------------------------------------------------------------

package warp_scheduler_pkg;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

endpackage

module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS     = 4,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_WARPS-1:0]     warp_participate_mask,
    input  logic                     fetch_valid,
    input  logic                     decoded_mem_access,
    input  logic                     lsu_done,
    input  logic                     decoded_ret,
    output logic [NUM_WARPS-1:0]     warp_enable,
    output warp_state_t              warp_state,
    output logic [WARP_ID_WIDTH-1:0] current_warp,
    output logic                     busy,
    output logic                     done
`ifdef WARP_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_cycles,
    output logic [31:0]              perf_retired
`endif
);

    // Handshake semantics with the datapath.
    // fetch_valid and lsu_done are level/pulse "ready" indications from the
    // fetcher and the LSU. They are sampled only on a rising edge where the
    // scheduler is waiting for them:
    //   - fetch_valid: in an armed FETCH cycle
    //   - lsu_done:    in a WAIT cycle
    // A rising edge with the indication high ends the wait. The indications
    // are ignored in every other phase. The scheduler never back-pressures
    // them; the current phase is the only acknowledgement.

    // Kernel-scoped bookkeeping.
    logic [NUM_WARPS-1:0] mask_q;       // participate mask latched on start
    logic [NUM_WARPS-1:0] retired;      // warps that have executed a return
    logic                 fetch_armed;  // FETCH has spent its first cycle

    // One-hot helper used for warp_enable and the retire bit.
    function automatic logic [NUM_WARPS-1:0] warp_onehot(
        input logic [WARP_ID_WIDTH-1:0] w
    );
        logic [NUM_WARPS-1:0] oh;
        oh    = '0;
        oh[w] = 1'b1;
        return oh;
    endfunction

    // -------------------------------------------------------------------------
    // First warp of a kernel: the lowest-indexed participating warp.
    // first_found is low for an all-zero mask; that kernel goes straight to DONE.
    // -------------------------------------------------------------------------
    logic                     first_found;
    logic [WARP_ID_WIDTH-1:0] first_warp;

    always_comb begin
        first_found = 1'b0;
        first_warp  = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!first_found && warp_participate_mask[i]) begin
                first_found = 1'b1;
                first_warp  = WARP_ID_WIDTH'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Retire vector as it will look after the current UPDATE cycle. The next-warp
    // search must use this value, so a warp that returns now is not re-picked.
    // -------------------------------------------------------------------------
    logic [NUM_WARPS-1:0] retired_upd;

    always_comb begin
        retired_upd = retired;
        if (decoded_ret) begin
            retired_upd = retired | warp_onehot(current_warp);
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin next-warp search.
    // The search starts at current_warp+1 and wraps modulo NUM_WARPS; the wrap
    // comes free from the power-of-two index width. The last candidate
    // (offset NUM_WARPS) is the current warp itself, so a lone surviving warp
    // is re-selected.
    // -------------------------------------------------------------------------
    logic                     next_found;
    logic [WARP_ID_WIDTH-1:0] next_warp;
    logic [WARP_ID_WIDTH-1:0] cand;

    always_comb begin
        next_found = 1'b0;
        next_warp  = current_warp;
        cand       = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand = current_warp + WARP_ID_WIDTH'(i);
            if (!next_found && mask_q[cand] && !retired_upd[cand]) begin
                next_found = 1'b1;
                next_warp  = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Phase FSM. warp_state is the state register itself. warp_enable, busy,
    // done and current_warp are registered alongside the state transition.
    //
    // FETCH always spends one cycle before fetch_valid is considered. The
    // fetcher needs that cycle to react to the new warp_enable, so a stale
    // fetch_valid belonging to the previous warp cannot be taken. Together
    // with DECODE, REQUEST, EXECUTE and UPDATE, this gives a 6-cycle
    // instruction when fetch_valid is already high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warp_state   <= WARP_IDLE;
            current_warp <= '0;
            warp_enable  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            retired      <= '0;
            mask_q       <= '0;
            fetch_armed  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (warp_state)
                WARP_IDLE: begin
                    if (start) begin
                        mask_q  <= warp_participate_mask;
                        retired <= '0;
                        busy    <= 1'b1;
                        if (first_found) begin
                            warp_state   <= WARP_FETCH;
                            current_warp <= first_warp;
                            warp_enable  <= warp_onehot(first_warp);
                            fetch_armed  <= 1'b0;
                        end else begin
                            // Nothing to run: report completion right away.
                            warp_state <= WARP_DONE;
                            done       <= 1'b1;
                        end
                    end
                end

                WARP_FETCH: begin
                    if (!fetch_armed) begin
                        fetch_armed <= 1'b1;
                    end else if (fetch_valid) begin
                        warp_state <= WARP_DECODE;
                    end
                end

                WARP_DECODE: begin
                    warp_state <= WARP_REQUEST;
                end

                WARP_REQUEST: begin
                    if (decoded_mem_access) begin
                        warp_state <= WARP_WAIT;
                    end else begin
                        warp_state <= WARP_EXECUTE;
                    end
                end

                WARP_WAIT: begin
                    if (lsu_done) begin
                        warp_state <= WARP_EXECUTE;
                    end
                end

                WARP_EXECUTE: begin
                    warp_state <= WARP_UPDATE;
                end

                WARP_UPDATE: begin
                    retired <= retired_upd;
                    if (next_found) begin
                        warp_state   <= WARP_FETCH;
                        current_warp <= next_warp;
                        warp_enable  <= warp_onehot(next_warp);
                        fetch_armed  <= 1'b0;
                    end else begin
                        // current_warp keeps the last served warp; only the
                        // enable drops.
                        warp_state  <= WARP_DONE;
                        warp_enable <= '0;
                        done        <= 1'b1;
                    end
                end

                WARP_DONE: begin
                    warp_state <= WARP_IDLE;
                    busy       <= 1'b0;
                end

                default: begin
                    warp_state  <= WARP_IDLE;
                    warp_enable <= '0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef WARP_SCHED_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters.
    // Both clear on an accepted start, which is only possible while idle.
    // Both hold at all-ones instead of wrapping.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
        end else if (warp_state == WARP_IDLE && start) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
        end else begin
            if (busy && perf_cycles != 32'hFFFF_FFFF) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (warp_state == WARP_UPDATE && perf_retired != 32'hFFFF_FFFF) begin
                perf_retired <= perf_retired + 32'd1;
            end
        end
    end
`endif

endmodule
